// File: rtl/bell_tone_driver.sv
// Purpose : turns each accepted strike edge into one fixed-length square-wave burst on the buzzer, then a forced silent gap.
// Latency : an edge sampled on cycle N gives buzz=1 and busy=1 on cycle N+1; all outputs are registered.
// Backpr. : none upstream; one strike may wait behind the running burst/gap, further edges are dropped and flagged in overrun.
//
// Ports:
//   clk, rst          - system clock (rising edge), asynchronous active-high reset
//   en                - 1 accepts new strike edges; 0 ignores them and discards a waiting strike
//   strike            - strike level from the bell stage, synchronous to clk
//   cnt_clr           - synchronous clear of strike_cnt and overrun (wins over a same-cycle update)
//   buzz              - square wave to the buzzer
//   busy              - high while a burst or gap is running
//   strike_cnt        - number of accepted strikes, wraps
//   overrun           - sticky, a strike was dropped because one was already waiting
//
// Optional macro BELL_DECAY_EN: mutes every odd tone period in the second half of the burst.
module bell_tone_driver #(
    parameter int TONE_HALF = 5000,
    parameter int BURST_LEN = 1000000,
    parameter int GAP_LEN   = 200000,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             strike,
    input  logic             cnt_clr,
    output logic             buzz,
    output logic             busy,
    output logic [CNT_W-1:0] strike_cnt,
    output logic             overrun
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TONE = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam int TW = $clog2(BURST_LEN);
    localparam int HW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    logic [1:0]    state;
    logic [TW-1:0] tone_timer;
    logic [HW-1:0] half_cnt;
    logic [GW-1:0] gap_timer;
    logic          phase;
    logic          per_odd;
    logic          pending;
    logic          strike_prev;

    logic          edge_det;
    logic          accept;
    logic          drop;
    logic          tone_last;
    logic          gap_last;
    logic          half_wrap;
    logic [TW-1:0] timer_nxt;
    logic          phase_nxt;
    logic          per_odd_nxt;
    logic          buzz_nxt;

    always_comb begin
        edge_det    = strike & ~strike_prev & en;
        // pending is never set in IDLE, so an idle edge is always accepted
        accept      = edge_det & ~pending;
        drop        = edge_det & pending;
        tone_last   = (tone_timer == TW'(BURST_LEN - 1));
        gap_last    = (gap_timer == GW'(GAP_LEN - 1));
        half_wrap   = (half_cnt == HW'(TONE_HALF - 1));
        timer_nxt   = tone_timer + 1'b1;
        phase_nxt   = half_wrap ? ~phase : phase;
        // a new tone period begins whenever the phase returns high
        per_odd_nxt = (half_wrap & ~phase) ? ~per_odd : per_odd;
        buzz_nxt    = phase_nxt;
`ifdef BELL_DECAY_EN
        if ((timer_nxt >= TW'(BURST_LEN / 2)) && per_odd_nxt)
            buzz_nxt = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            tone_timer  <= '0;
            half_cnt    <= '0;
            gap_timer   <= '0;
            phase       <= 1'b0;
            per_odd     <= 1'b0;
            pending     <= 1'b0;
            strike_prev <= 1'b1;   // a strike already high at release is not an edge
            buzz        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            strike_prev <= strike;
            case (state)
                S_IDLE: begin
                    if (edge_det) begin
                        state      <= S_TONE;
                        busy       <= 1'b1;
                        buzz       <= 1'b1;
                        tone_timer <= '0;
                        half_cnt   <= '0;
                        phase      <= 1'b1;
                        per_odd    <= 1'b0;
                    end
                end
                S_TONE: begin
                    if (tone_last) begin
                        state     <= S_GAP;
                        gap_timer <= '0;
                        buzz      <= 1'b0;
                    end else begin
                        tone_timer <= timer_nxt;
                        half_cnt   <= half_wrap ? '0 : half_cnt + 1'b1;
                        phase      <= phase_nxt;
                        per_odd    <= per_odd_nxt;
                        buzz       <= buzz_nxt;
                    end
                    if (accept)
                        pending <= 1'b1;
                    else if (!en)
                        pending <= 1'b0;
                end
                S_GAP: begin
                    if (gap_last) begin
                        pending <= 1'b0;
                        // an edge landing on the last gap cycle starts the next burst directly
                        if ((pending & en) | edge_det) begin
                            state      <= S_TONE;
                            buzz       <= 1'b1;
                            tone_timer <= '0;
                            half_cnt   <= '0;
                            phase      <= 1'b1;
                            per_odd    <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_timer <= gap_timer + 1'b1;
                        if (accept)
                            pending <= 1'b1;
                        else if (!en)
                            pending <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    buzz    <= 1'b0;
                    pending <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strike_cnt <= '0;
            overrun    <= 1'b0;
        end else if (cnt_clr) begin
            strike_cnt <= '0;
            overrun    <= 1'b0;
        end else begin
            if (accept)
                strike_cnt <= strike_cnt + 1'b1;
            if (drop)
                overrun <= 1'b1;
        end
    end

endmodule
